// File: rtl/ex_muldiv_unit_if.sv
// Operand/result bundle between the ID/EX stage and the iterative RV32M multiply/divide unit.
// The slave side is the unit; the master side is the pipeline driving it.
interface ex_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            md_valid_in;
  logic [2:0]      md_func3_in;
  logic [XLEN-1:0] md_rv1_in;
  logic [XLEN-1:0] md_rv2_in;
  logic [4:0]      md_rd_in;
  logic            md_flush_in;
  logic            md_stall_out;
  logic            md_busy_out;
  logic            md_result_valid_out;
  logic [XLEN-1:0] md_result_out;
  logic [4:0]      md_rd_out;

  modport slave (
    input  md_valid_in,
    input  md_func3_in,
    input  md_rv1_in,
    input  md_rv2_in,
    input  md_rd_in,
    input  md_flush_in,
    output md_stall_out,
    output md_busy_out,
    output md_result_valid_out,
    output md_result_out,
    output md_rd_out
  );

  modport master (
    output md_valid_in,
    output md_func3_in,
    output md_rv1_in,
    output md_rv2_in,
    output md_rd_in,
    output md_flush_in,
    input  md_stall_out,
    input  md_busy_out,
    input  md_result_valid_out,
    input  md_result_out,
    input  md_rd_out
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on magnitudes,
// one bit per cycle, with a single-cycle path for divide-by-zero and signed overflow.
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  ex_muldiv_unit_if.slave     md
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2:0]          func3_q, func3_d;
  logic                neg_q, neg_d;
  logic [4:0]          rd_q, rd_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [4:0]          rd_out_q, rd_out_d;

  // Operand decode at the start edge
  logic            start;
  logic            in_div;
  logic            s1_signed, s2_signed;
  logic            s1, s2;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;
  logic            neg_in;

  always_comb begin
    start     = md.md_valid_in && !md.md_flush_in;
    in_div    = md.md_func3_in[2];
    s1_signed = in_div ? !md.md_func3_in[0] : (md.md_func3_in[1:0] != 2'b11);
    s2_signed = in_div ? !md.md_func3_in[0] : !md.md_func3_in[1];
    s1        = s1_signed && md.md_rv1_in[XLEN-1];
    s2        = s2_signed && md.md_rv2_in[XLEN-1];
    mag1      = s1 ? (~md.md_rv1_in + 1'b1) : md.md_rv1_in;
    mag2      = s2 ? (~md.md_rv2_in + 1'b1) : md.md_rv2_in;
    div_zero  = (md.md_rv2_in == '0);
    div_ovf   = !md.md_func3_in[0] && (md.md_rv1_in == {1'b1, {(XLEN-1){1'b0}}})
                && (md.md_rv2_in == '1);
    fast      = in_div && (div_zero || div_ovf);
    // Overflow quotient equals rv1 (the most negative value); overflow remainder is zero.
    if (md.md_func3_in[1]) begin
      fast_res = div_zero ? md.md_rv1_in : '0;
    end else begin
      fast_res = div_zero ? '1 : md.md_rv1_in;
    end
    // Remainder follows the dividend sign; everything else follows the sign product.
    neg_in    = (in_div && md.md_func3_in[1]) ? s1 : (s1 ^ s2);
  end

  // One iteration of the datapath
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       div_shift, div_diff;
  logic                div_ge;
  logic [2*XLEN-1:0]   div_next;
  logic [2*XLEN-1:0]   iter_next;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     div_val, div_fix;
  logic [XLEN-1:0]     final_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};

    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = !div_diff[XLEN];
    div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                 acc_q[XLEN-2:0], div_ge};

    iter_next = func3_q[2] ? div_next : mul_next;

    prod_fix  = neg_q ? (~iter_next + 1'b1) : iter_next;
    div_val   = func3_q[1] ? iter_next[2*XLEN-1:XLEN] : iter_next[XLEN-1:0];
    div_fix   = neg_q ? (~div_val + 1'b1) : div_val;

    if (func3_q[2]) begin
      final_res = div_fix;
    end else if (func3_q[1:0] == 2'b00) begin
      final_res = prod_fix[XLEN-1:0];
    end else begin
      final_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    func3_d  = func3_q;
    neg_d    = neg_q;
    rd_d     = rd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          func3_d = md.md_func3_in;
          neg_d   = neg_in;
          rd_d    = md.md_rd_in;
          cnt_d   = '0;
          if (fast) begin
            result_d = fast_res;
            rd_out_d = md.md_rd_in;
            state_d  = StDone;
          end else begin
            // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
            acc_d   = {{XLEN{1'b0}}, (in_div ? mag1 : mag2)};
            opnd_d  = in_div ? mag2 : mag1;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (md.md_flush_in) begin
          result_d = '0;
          rd_out_d = '0;
          state_d  = StIdle;
        end else begin
          acc_d = iter_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(XLEN - 1)) begin
            result_d = final_res;
            rd_out_d = rd_q;
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        if (md.md_flush_in) begin
          result_d = '0;
          rd_out_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      func3_q  <= '0;
      neg_q    <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      func3_q  <= func3_d;
      neg_q    <= neg_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  // A flush in DONE suppresses the strobe in that same cycle.
  always_comb begin
    md.md_stall_out        = ((state_q == StIdle) && start) || (state_q == StCalc);
    md.md_busy_out         = (state_q != StIdle);
    md.md_result_valid_out = (state_q == StDone) && !md.md_flush_in;
    md.md_result_out       = result_q;
    md.md_rd_out           = rd_out_q;
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vector table, random ops against an
// arithmetic reference model, and hand sequences for flush, back-to-back and async reset.
module tb_ex_muldiv_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   vcount;
  logic [31:0] last_res;

  ex_muldiv_unit_if #(.XLEN(32)) bus ();

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.md_result_valid_out) vcount <= vcount + 1;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa, sb, ub;
    longint unsigned ua, uub;
    logic [63:0]     p;
    int              si, sj, sq;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'h0, b});
    ua  = {32'h0, a};
    uub = {32'h0, b};
    si  = $signed(a);
    sj  = $signed(b);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * uub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sq = si / sj;
        return sq;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        sq = si % sj;
        return sq;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 0;
    return 32;
  endfunction

  // Call just after a rising edge. lat = edges after the start edge before the strobe.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat,
                        input string tag);
    int lat;
    int stalls;
    bit got;
    bus.md_func3_in = f3;
    bus.md_rv1_in   = a;
    bus.md_rv2_in   = b;
    bus.md_rd_in    = rd;
    bus.md_valid_in = 1'b1;
    lat    = -1;
    stalls = 0;
    got    = 1'b0;
    @(negedge clk);
    if (bus.md_stall_out) stalls++;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.md_result_valid_out) begin
        got = 1'b1;
        check({tag, "/result"}, bus.md_result_out, exp_res);
        check({tag, "/rd"}, {27'h0, bus.md_rd_out}, {27'h0, rd});
        check({tag, "/stall_in_done"}, {31'h0, bus.md_stall_out}, 32'h0);
        check({tag, "/busy_in_done"}, {31'h0, bus.md_busy_out}, 32'h1);
      end else begin
        if (bus.md_stall_out) stalls++;
        if (lat == 5) begin
          check({tag, "/busy_in_calc"}, {31'h0, bus.md_busy_out}, 32'h1);
          check({tag, "/result_hold"}, bus.md_result_out, last_res);
        end
      end
    end
    check({tag, "/latency"}, got ? lat : -1, exp_lat);
    check({tag, "/stall_cycles"}, stalls, exp_lat + 1);
    @(posedge clk);
    #1;
    bus.md_valid_in = 1'b0;
    last_res = exp_res;
  endtask

  initial begin
    int v0;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;
    int sel;

    checks   = 0;
    failures = 0;
    vcount   = 0;
    last_res = 32'h0;

    vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 32};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 32};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 32};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'hFFFF_FFFF, 32};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD, 32};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 32};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         5'd7,  32'd14,        32};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         5'd8,  32'd2,         32};
    vecs[8]  = '{3'd4, 32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF, 0};
    vecs[9]  = '{3'd6, 32'd5,         32'd0,         5'd10, 32'd5,         0};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0,         0};
    vecs[12] = '{3'd5, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 0};
    vecs[13] = '{3'd7, 32'd7,         32'd0,         5'd14, 32'd7,         0};
    vecs[14] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 32};
    vecs[15] = '{3'd4, 32'h8000_0000, 32'd1,         5'd16, 32'h8000_0000, 32};
    vecs[16] = '{3'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd17, 32'hFFFF_FFFF, 32};
    vecs[17] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 5'd18, 32'hFFFF_FFFD, 32};

    reset = 1'b1;
    bus.md_valid_in = 1'b0;
    bus.md_flush_in = 1'b0;
    bus.md_func3_in = 3'd0;
    bus.md_rv1_in   = 32'h0;
    bus.md_rv2_in   = 32'h0;
    bus.md_rd_in    = 5'd0;
    #1;
    check("reset/busy", {31'h0, bus.md_busy_out}, 32'h0);
    check("reset/stall", {31'h0, bus.md_stall_out}, 32'h0);
    check("reset/valid", {31'h0, bus.md_result_valid_out}, 32'h0);
    check("reset/result", bus.md_result_out, 32'h0);
    check("reset/rd", {27'h0, bus.md_rd_out}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat,
             $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      rd  = 5'($urandom_range(0, 31));
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'h0;
      if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 2) b = $urandom_range(1, 15);
      run_op(f3, a, b, rd, ref_md(f3, a, b), ref_lat(f3, a, b), $sformatf("rand%0d", i));
    end

    // Back-to-back: the second op starts in the IDLE cycle right after DONE.
    v0 = vcount;
    run_op(3'd5, 32'd100, 32'd7, 5'd20, 32'd14, 32, "b2b_divu");
    run_op(3'd0, 32'd3, 32'd4, 5'd21, 32'd12, 32, "b2b_mul");
    #1;
    check("b2b/strobe_count", vcount - v0, 2);

    // Flush on the 10th CALC cycle.
    v0 = vcount;
    bus.md_func3_in = 3'd5;
    bus.md_rv1_in   = 32'd1000;
    bus.md_rv2_in   = 32'd3;
    bus.md_rd_in    = 5'd22;
    bus.md_valid_in = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    bus.md_flush_in = 1'b1;
    @(posedge clk);
    #1;
    bus.md_flush_in = 1'b0;
    bus.md_valid_in = 1'b0;
    @(negedge clk);
    check("flush_calc/busy", {31'h0, bus.md_busy_out}, 32'h0);
    check("flush_calc/stall", {31'h0, bus.md_stall_out}, 32'h0);
    check("flush_calc/result", bus.md_result_out, 32'h0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_calc/no_strobe", vcount - v0, 0);
    last_res = 32'h0;

    // Flush in DONE, with valid still high so IDLE must also refuse to start.
    run_op(3'd0, 32'd6, 32'd7, 5'd23, 32'd42, 32, "pre_flush_done");
    v0 = vcount;
    bus.md_func3_in = 3'd4;
    bus.md_rv1_in   = 32'd5;
    bus.md_rv2_in   = 32'd0;
    bus.md_rd_in    = 5'd24;
    bus.md_valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.md_flush_in = 1'b1;
    #1;
    check("flush_done/valid", {31'h0, bus.md_result_valid_out}, 32'h0);
    check("flush_idle/stall", {31'h0, bus.md_stall_out}, 32'h0);
    @(posedge clk);
    #1;
    check("flush_done/result", bus.md_result_out, 32'h0);
    check("flush_done/rd", {27'h0, bus.md_rd_out}, 32'h0);
    @(posedge clk);
    #1;
    check("flush_idle/busy", {31'h0, bus.md_busy_out}, 32'h0);
    bus.md_flush_in = 1'b0;
    bus.md_valid_in = 1'b0;
    check("flush_done/no_strobe", vcount - v0, 0);
    last_res = 32'h0;

    // Asynchronous reset in the middle of CALC.
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 32, "pre_reset");
    bus.md_func3_in = 3'd5;
    bus.md_rv1_in   = 32'd1000;
    bus.md_rv2_in   = 32'd7;
    bus.md_rd_in    = 5'd9;
    bus.md_valid_in = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    bus.md_valid_in = 1'b0;
    #1;
    check("async_reset/busy", {31'h0, bus.md_busy_out}, 32'h0);
    check("async_reset/stall", {31'h0, bus.md_stall_out}, 32'h0);
    check("async_reset/valid", {31'h0, bus.md_result_valid_out}, 32'h0);
    check("async_reset/result", bus.md_result_out, 32'h0);
    check("async_reset/rd", {27'h0, bus.md_rd_out}, 32'h0);
    #3;
    reset = 1'b0;
    last_res = 32'h0;
    @(posedge clk);
    #1;
    run_op(3'd5, 32'd9, 32'd3, 5'd25, 32'd3, 32, "post_reset_divu");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
